// File: rtl/lenet_axil_pkg.sv
// Shared constants and state types for the LeNet AXI4-Lite register bridge.
// Addresses are byte addresses of the eight 32-bit word registers.
package lenet_axil_pkg;

    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_WGT    = 5'h04;
    localparam logic [4:0] ADDR_BIAS   = 5'h08;
    localparam logic [4:0] ADDR_FMAP   = 5'h0C;
    localparam logic [4:0] ADDR_COUNT  = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h14;
    localparam logic [4:0] ADDR_RESULT = 5'h18;
    localparam logic [4:0] ADDR_SRST   = 5'h1C;

    localparam int WGT_CNT_W  = 12;
    localparam int BIAS_CNT_W = 4;
    localparam int FMAP_CNT_W = 10;

    typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/lenet_axil_regs.sv
// AXI4-Lite slave: control/status registers for the LeNet core plus a bridge
// that turns single-beat writes into valid/ready word streams.
module lenet_axil_regs
    import lenet_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              core_start,
    output logic                              core_srst,
    output logic [31:0]                       wgt_data,
    output logic                              wgt_valid,
    input  logic                              wgt_ready,
    output logic [31:0]                       bias_data,
    output logic                              bias_valid,
    input  logic                              bias_ready,
    output logic [31:0]                       fmap_data,
    output logic                              fmap_valid,
    input  logic                              fmap_ready,
    input  logic                              core_done,
    input  logic [3:0]                        core_result
);

    wr_state_t              wr_state_q;
    logic                   awready_q, wready_q, bvalid_q;
    logic [4:0]             awaddr_q;
    logic [31:0]            wdata_q, push_data_q;
    logic [3:0]             wstrb_q;
    logic [2:0]             push_sel_q;
    logic                   start_q, srst_q, done_q;
    logic [3:0]             result_q;
    logic [WGT_CNT_W-1:0]   cnt_wgt_q;
    logic [BIAS_CNT_W-1:0]  cnt_bias_q;
    logic [FMAP_CNT_W-1:0]  cnt_fmap_q;

    rd_state_t              rd_state_q;
    logic                   arready_q, rvalid_q;
    logic [31:0]            rdata_q;

    logic [4:0]             wr_addr_d, wr_word_d, rd_word_d;
    logic [31:0]            wr_data_d, rd_mux_d;
    logic [3:0]             wr_strb_d;
    logic                   wr_fire_d, ctrl_wr_d, srst_wr_d, push_ack_d;
    logic                   cnt_clr_d, done_clr_d;

    // A channel already latched supplies its held value; otherwise the live
    // bus value is used so a same-cycle AW+W completes on the handshake edge.
    always_comb begin
        wr_addr_d  = awready_q ? S_AXI_AWADDR : awaddr_q;
        wr_data_d  = wready_q  ? S_AXI_WDATA  : wdata_q;
        wr_strb_d  = wready_q  ? S_AXI_WSTRB  : wstrb_q;
        wr_word_d  = {wr_addr_d[4:2], 2'b00};
        wr_fire_d  = (wr_state_q == W_IDLE) && (!awready_q || S_AXI_AWVALID)
                     && (!wready_q || S_AXI_WVALID);
        ctrl_wr_d  = wr_fire_d && (wr_word_d == ADDR_CTRL) && wr_strb_d[0];
        srst_wr_d  = wr_fire_d && (wr_word_d == ADDR_SRST) && wr_strb_d[0];
        push_ack_d = |(push_sel_q & {fmap_ready, bias_ready, wgt_ready});
        cnt_clr_d  = srst_q || (ctrl_wr_d && wr_data_d[0] && !start_q);
        done_clr_d = srst_q || (ctrl_wr_d && !wr_data_d[0]);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q  <= W_IDLE;
            awready_q   <= 1'b1;
            wready_q    <= 1'b1;
            bvalid_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            push_data_q <= '0;
            push_sel_q  <= '0;
            start_q     <= 1'b0;
            srst_q      <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (awready_q && S_AXI_AWVALID) begin
                        awaddr_q  <= S_AXI_AWADDR;
                        awready_q <= 1'b0;
                    end
                    if (wready_q && S_AXI_WVALID) begin
                        wdata_q  <= S_AXI_WDATA;
                        wstrb_q  <= S_AXI_WSTRB;
                        wready_q <= 1'b0;
                    end
                    if (wr_fire_d) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        case (wr_word_d)
                            ADDR_WGT: begin
                                push_sel_q  <= 3'b001;
                                push_data_q <= wr_data_d;
                                wr_state_q  <= W_PUSH;
                            end
                            ADDR_BIAS: begin
                                push_sel_q  <= 3'b010;
                                push_data_q <= wr_data_d;
                                wr_state_q  <= W_PUSH;
                            end
                            ADDR_FMAP: begin
                                push_sel_q  <= 3'b100;
                                push_data_q <= wr_data_d;
                                wr_state_q  <= W_PUSH;
                            end
                            default: begin
                                bvalid_q   <= 1'b1;
                                wr_state_q <= W_RESP;
                            end
                        endcase
                        if (ctrl_wr_d) start_q <= wr_data_d[0];
                        if (srst_wr_d) srst_q  <= wr_data_d[0];
                    end
                end
                W_PUSH: begin
                    if (push_ack_d) begin
                        push_sel_q <= '0;
                        bvalid_q   <= 1'b1;
                        wr_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Counters saturate; a soft-reset or start edge clear outranks any push.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cnt_wgt_q  <= '0;
            cnt_bias_q <= '0;
            cnt_fmap_q <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            if (cnt_clr_d) begin
                cnt_wgt_q  <= '0;
                cnt_bias_q <= '0;
                cnt_fmap_q <= '0;
            end else if (wr_state_q == W_PUSH && push_ack_d) begin
                if (push_sel_q[0] && !(&cnt_wgt_q))  cnt_wgt_q  <= cnt_wgt_q + WGT_CNT_W'(1);
                if (push_sel_q[1] && !(&cnt_bias_q)) cnt_bias_q <= cnt_bias_q + BIAS_CNT_W'(1);
                if (push_sel_q[2] && !(&cnt_fmap_q)) cnt_fmap_q <= cnt_fmap_q + FMAP_CNT_W'(1);
            end
            if (core_done) begin
                done_q   <= 1'b1;
                result_q <= core_result;
            end else if (done_clr_d) begin
                done_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_word_d = {S_AXI_ARADDR[4:2], 2'b00};
        rd_mux_d  = '0;
        case (rd_word_d)
            ADDR_CTRL:   rd_mux_d = {31'b0, start_q};
            ADDR_COUNT:  rd_mux_d = {6'b0, cnt_fmap_q, cnt_bias_q, cnt_wgt_q};
            ADDR_STATUS: rd_mux_d = {30'b0, wr_state_q == W_PUSH, done_q};
            ADDR_RESULT: rd_mux_d = {28'b0, result_q};
            ADDR_SRST:   rd_mux_d = {31'b0, srst_q};
            default:     rd_mux_d = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        rdata_q    <= rd_mux_d;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0],
                         wr_addr_d[1:0], wr_strb_d[3:1]};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign core_start    = start_q;
    assign core_srst     = srst_q;
    assign wgt_valid     = push_sel_q[0];
    assign bias_valid    = push_sel_q[1];
    assign fmap_valid    = push_sel_q[2];
    assign wgt_data      = push_data_q;
    assign bias_data     = push_data_q;
    assign fmap_data     = push_data_q;

endmodule

// File: tb/tb_lenet_axil_regs.sv
// Randomized self-checking bench for lenet_axil_regs against a register-level
// model of counts, done/result flags and the expected word order per stream.
module tb_lenet_axil_regs;

    localparam logic [4:0] A_CTRL = 5'h00, A_WGT = 5'h04, A_BIAS = 5'h08, A_FMAP = 5'h0C;
    localparam logic [4:0] A_COUNT = 5'h10, A_STATUS = 5'h14, A_RESULT = 5'h18, A_SRST = 5'h1C;

    logic        clk = 1'b0;
    logic        S_AXI_ARESETN = 1'b0;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        core_start, core_srst;
    logic [31:0] wgt_data, bias_data, fmap_data;
    logic        wgt_valid, bias_valid, fmap_valid;
    logic        wgt_ready = 1'b1, bias_ready = 1'b1, fmap_ready = 1'b1;
    logic        core_done = 1'b0;
    logic [3:0]  core_result = '0;

    always #5 clk = ~clk;

    lenet_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .core_start(core_start), .core_srst(core_srst),
        .wgt_data(wgt_data), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
        .bias_data(bias_data), .bias_valid(bias_valid), .bias_ready(bias_ready),
        .fmap_data(fmap_data), .fmap_valid(fmap_valid), .fmap_ready(fmap_ready),
        .core_done(core_done), .core_result(core_result)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    int          m_wgt = 0, m_bias = 0, m_fmap = 0;
    bit          m_done = 0;
    logic [3:0]  m_result = '0;

    logic [31:0] obs_wgt[$], obs_bias[$], obs_fmap[$];
    logic [31:0] exp_wgt[$], exp_bias[$], exp_fmap[$];

    always @(posedge clk) begin
        if (wgt_valid && wgt_ready)   obs_wgt.push_back(wgt_data);
        if (bias_valid && bias_ready) obs_bias.push_back(bias_data);
        if (fmap_valid && fmap_ready) obs_fmap.push_back(fmap_data);
    end

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic logic [31:0] exp_count();
        logic [31:0] v;
        v = 32'(sat(m_fmap, 1023)) * 65536 + 32'(sat(m_bias, 15)) * 4096 + 32'(sat(m_wgt, 4095));
        return v;
    endfunction

    function automatic int q_mism(input logic [31:0] a[$], input logic [31:0] b[$]);
        int m = 0;
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) m++;
        return m;
    endfunction

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, output bit ok, output int bw, output logic [1:0] resp);
        int t, aw_start, w_start;
        bit aw_done, w_done, hs_aw, hs_w, got;
        aw_start = (lead < 0) ? -lead : 0;
        w_start  = (lead > 0) ? lead : 0;
        aw_done = 0; w_done = 0; got = 0; t = 0; bw = 0; resp = 2'bxx;
        @(posedge clk); #1;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        while (!(aw_done && w_done) && t < 64) begin
            S_AXI_AWVALID = (t >= aw_start) && !aw_done;
            S_AXI_WVALID  = (t >= w_start) && !w_done;
            @(negedge clk);
            hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
            hs_w  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge clk); #1;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            t++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        while (!got && bw < 200) begin
            @(negedge clk);
            if (S_AXI_BVALID) begin got = 1; resp = S_AXI_BRESP; end
            else bw++;
            @(posedge clk); #1;
        end
        S_AXI_BREADY = 1'b0;
        ok = aw_done && w_done && got;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output bit ok, output int rw);
        int t;
        bit hs, got;
        hs = 0; got = 0; t = 0; rw = 0; d = 'x; resp = 2'bxx;
        @(posedge clk); #1;
        S_AXI_ARADDR = a;
        while (!hs && t < 64) begin
            S_AXI_ARVALID = 1'b1;
            @(negedge clk);
            hs = S_AXI_ARREADY;
            @(posedge clk); #1;
            t++;
        end
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        while (hs && !got && rw < 200) begin
            @(negedge clk);
            if (S_AXI_RVALID) begin got = 1; d = S_AXI_RDATA; resp = S_AXI_RRESP; end
            else rw++;
            @(posedge clk); #1;
        end
        S_AXI_RREADY = 1'b0;
        ok = hs && got;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; bit ok; int w;
        logic [9:0] flags;
        S_AXI_ARESETN = 1'b0;
        repeat (3) @(posedge clk);
        #1 S_AXI_ARESETN = 1'b1;
        @(negedge clk);
        flags = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                 wgt_valid, bias_valid, fmap_valid, core_start, core_srst};
        n_checks++;
        if (flags !== 10'b1110000000) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, 10'b1110000000); end
        n_checks++;
        if (S_AXI_RDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", S_AXI_RDATA); end
        axi_read(A_STATUS, d, r, ok, w);
        n_checks++;
        if (!ok || d !== 32'h0 || r !== 2'b00 || w != 0) begin n_fail++; $display("FAIL reset_status: ok %0d data %h resp %b wait %0d expected 1 0 00 0", ok, d, r, w); end
        axi_read(A_RESULT, d, r, ok, w);
        n_checks++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin n_fail++; $display("FAIL reset_result: ok %0d data %h resp %b expected 0", ok, d, r); end
        axi_read(A_COUNT, d, r, ok, w);
        n_checks++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin n_fail++; $display("FAIL reset_count: ok %0d data %h resp %b expected 0", ok, d, r); end
        axi_write(A_SRST, 32'h1, 4'hF, 0, ok, w, r);
        n_checks++;
        if (!ok || core_srst !== 1'b1 || r !== 2'b00 || w != 0) begin n_fail++; $display("FAIL srst_set: ok %0d srst %b resp %b bwait %0d expected 1 1 00 0", ok, core_srst, r, w); end
        axi_read(A_SRST, d, r, ok, w);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL srst_readback: got %h expected 1", d); end
        axi_write(A_SRST, 32'h0, 4'hF, 0, ok, w, r);
        n_checks++;
        if (!ok || core_srst !== 1'b0) begin n_fail++; $display("FAIL srst_clear: ok %0d srst %b expected 0", ok, core_srst); end
        $display("test_reset done");
    endtask

    task automatic test_streams();
        logic [31:0] d; logic [1:0] r; bit ok; int w;
        int rw_, rb_, rf_, pick, lead, bad_ok, bad_lat, bad_resp;
        axi_write(A_CTRL, 32'h1, 4'hF, 0, ok, w, r);
        m_wgt = 0; m_bias = 0; m_fmap = 0;
        n_checks++;
        if (!ok || core_start !== 1'b1) begin n_fail++; $display("FAIL ctrl_start: ok %0d start %b expected 1", ok, core_start); end
        obs_wgt.delete(); obs_bias.delete(); obs_fmap.delete();
        exp_wgt.delete(); exp_bias.delete(); exp_fmap.delete();
        rw_ = 3220; rb_ = 10; rf_ = 784; bad_ok = 0; bad_lat = 0; bad_resp = 0;
        while (rw_ + rb_ + rf_ > 0) begin
            pick = int'($urandom_range(0, rw_ + rb_ + rf_ - 1));
            lead = int'($urandom_range(0, 6)) - 3;
            d = $urandom;
            if (pick < rw_) begin
                exp_wgt.push_back(d); rw_--; m_wgt++;
                axi_write(A_WGT, d, 4'($urandom), lead, ok, w, r);
            end else if (pick < rw_ + rb_) begin
                exp_bias.push_back(d); rb_--; m_bias++;
                axi_write(A_BIAS, d, 4'($urandom), lead, ok, w, r);
            end else begin
                exp_fmap.push_back(d); rf_--; m_fmap++;
                axi_write(A_FMAP, d, 4'($urandom), lead, ok, w, r);
            end
            if (!ok) bad_ok++;
            if (w != 1) bad_lat++;
            if (r !== 2'b00) bad_resp++;
        end
        n_checks++;
        if (bad_ok != 0) begin n_fail++; $display("FAIL stream_handshake: %0d incomplete writes, expected 0", bad_ok); end
        n_checks++;
        if (bad_lat != 0) begin n_fail++; $display("FAIL stream_blatency: %0d writes with BVALID delay other than 1, expected 0", bad_lat); end
        n_checks++;
        if (bad_resp != 0) begin n_fail++; $display("FAIL stream_bresp: %0d non-OKAY responses, expected 0", bad_resp); end
        n_checks++;
        if (obs_wgt.size() != exp_wgt.size() || q_mism(obs_wgt, exp_wgt) != 0) begin n_fail++; $display("FAIL wgt_stream: got %0d words (%0d wrong) expected %0d", obs_wgt.size(), q_mism(obs_wgt, exp_wgt), exp_wgt.size()); end
        n_checks++;
        if (obs_bias.size() != exp_bias.size() || q_mism(obs_bias, exp_bias) != 0) begin n_fail++; $display("FAIL bias_stream: got %0d words (%0d wrong) expected %0d", obs_bias.size(), q_mism(obs_bias, exp_bias), exp_bias.size()); end
        n_checks++;
        if (obs_fmap.size() != exp_fmap.size() || q_mism(obs_fmap, exp_fmap) != 0) begin n_fail++; $display("FAIL fmap_stream: got %0d words (%0d wrong) expected %0d", obs_fmap.size(), q_mism(obs_fmap, exp_fmap), exp_fmap.size()); end
        axi_read(A_COUNT, d, r, ok, w);
        n_checks++;
        if (!ok || d !== exp_count()) begin n_fail++; $display("FAIL stream_count: got %h expected %h", d, exp_count()); end
        $display("test_streams done: %0d/%0d/%0d words", obs_wgt.size(), obs_bias.size(), obs_fmap.size());
    endtask

    task automatic test_saturation();
        logic [31:0] d; logic [1:0] r; bit ok; int w, bad;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            axi_write(A_BIAS, $urandom, 4'hF, 0, ok, w, r); m_bias++;
            if (!ok) bad++;
        end
        for (int i = 0; i < 900; i++) begin
            axi_write(A_WGT, $urandom, 4'hF, 0, ok, w, r); m_wgt++;
            if (!ok) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL sat_writes: %0d incomplete, expected 0", bad); end
        axi_read(A_COUNT, d, r, ok, w);
        n_checks++;
        if (!ok || d !== exp_count()) begin n_fail++; $display("FAIL sat_count: got %h expected %h", d, exp_count()); end
        $display("test_saturation done: count %h", d);
    endtask

    task automatic test_backpressure();
        logic [31:0] d, rd; logic [1:0] r; bit ok; int w, stall_bad;
        d = $urandom;
        wgt_ready = 1'b0;
        @(posedge clk); #1;
        S_AXI_AWADDR = A_WGT; S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(wgt_valid === 1'b1 && wgt_data === d && S_AXI_BVALID === 1'b0)) stall_bad++;
        end
        n_checks++;
        if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stall: %0d bad stall cycles, expected 0", stall_bad); end
        axi_read(A_STATUS, rd, r, ok, w);
        n_checks++;
        if (!ok || rd !== {30'b0, 1'b1, m_done}) begin n_fail++; $display("FAIL bp_status_pending: got %h expected %h", rd, {30'b0, 1'b1, m_done}); end
        @(posedge clk); #1 wgt_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (S_AXI_BVALID !== 1'b0) begin n_fail++; $display("FAIL bp_bvalid_early: got %b expected 0", S_AXI_BVALID); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (S_AXI_BVALID !== 1'b1 || wgt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: bvalid %b wgt_valid %b expected 1 0", S_AXI_BVALID, wgt_valid); end
        S_AXI_BREADY = 1'b1;
        @(posedge clk); #1 S_AXI_BREADY = 1'b0;
        m_wgt++;
        @(negedge clk);
        n_checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || obs_wgt[obs_wgt.size()-1] !== d) begin n_fail++; $display("FAIL bp_complete: bvalid %b awready %b word %h expected 0 1 %h", S_AXI_BVALID, S_AXI_AWREADY, obs_wgt[obs_wgt.size()-1], d); end
        $display("test_backpressure done: word %h", d);
    endtask

    task automatic test_done();
        logic [31:0] d; logic [1:0] r; bit ok; int w;
        logic [3:0] res;
        for (int k = 0; k < 2; k++) begin
            res = (k == 0) ? 4'd7 : 4'($urandom);
            @(posedge clk); #1 core_result = res; core_done = 1'b1;
            @(posedge clk); #1 core_done = 1'b0; core_result = 4'($urandom);
            m_done = 1; m_result = res;
            axi_read(A_STATUS, d, r, ok, w);
            n_checks++;
            if (!ok || d !== {31'b0, m_done}) begin n_fail++; $display("FAIL done_status: got %h expected %h", d, {31'b0, m_done}); end
            axi_read(A_RESULT, d, r, ok, w);
            n_checks++;
            if (!ok || d !== {28'b0, m_result}) begin n_fail++; $display("FAIL done_result: got %h expected %h", d, {28'b0, m_result}); end
            axi_write(A_CTRL, 32'h0, 4'hF, 0, ok, w, r);
            m_done = 0;
            axi_read(A_STATUS, d, r, ok, w);
            n_checks++;
            if (!ok || d !== 32'h0 || core_start !== 1'b0) begin n_fail++; $display("FAIL done_clear: status %h start %b expected 0 0", d, core_start); end
            axi_read(A_RESULT, d, r, ok, w);
            n_checks++;
            if (!ok || d !== {28'b0, m_result}) begin n_fail++; $display("FAIL done_result_kept: got %h expected %h", d, {28'b0, m_result}); end
            $display("test_done pass %0d: result %0d", k, res);
        end
    endtask

    task automatic test_split_channels();
        logic [31:0] d, wd; logic [1:0] r; bit ok; int w;
        axi_write(A_CTRL, 32'h1, 4'hF, 3, ok, w, r);
        m_wgt = 0; m_bias = 0; m_fmap = 0;
        axi_read(A_COUNT, d, r, ok, w);
        n_checks++;
        if (core_start !== 1'b1 || d !== exp_count()) begin n_fail++; $display("FAIL aw_first: start %b count %h expected 1 %h", core_start, d, exp_count()); end
        wd = $urandom;
        axi_write(A_BIAS, wd, 4'h0, -3, ok, w, r);
        m_bias++;
        n_checks++;
        if (!ok || obs_bias[obs_bias.size()-1] !== wd) begin n_fail++; $display("FAIL w_first: ok %0d word %h expected %h", ok, obs_bias[obs_bias.size()-1], wd); end
        axi_read(A_COUNT, d, r, ok, w);
        n_checks++;
        if (d !== exp_count()) begin n_fail++; $display("FAIL w_first_count: got %h expected %h", d, exp_count()); end
        axi_write(A_CTRL, 32'h0, 4'h0, 0, ok, w, r);
        n_checks++;
        if (core_start !== 1'b1) begin n_fail++; $display("FAIL ctrl_wstrb: start %b expected 1", core_start); end
        axi_write(A_COUNT, $urandom, 4'hF, 1, ok, w, r);
        axi_read(A_COUNT, d, r, ok, w);
        n_checks++;
        if (d !== exp_count()) begin n_fail++; $display("FAIL ro_write: count %h expected %h", d, exp_count()); end
        axi_read(A_WGT, d, r, ok, w);
        n_checks++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin n_fail++; $display("FAIL stream_read: got %h resp %b expected 0 00", d, r); end
        $display("test_split_channels done");
    endtask

    task automatic test_done_race();
        logic [31:0] d; logic [1:0] r; bit ok; int w;
        logic [3:0] res;
        res = 4'($urandom);
        @(posedge clk); #1;
        S_AXI_AWADDR = A_CTRL; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; core_done = 1'b1; core_result = res;
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; core_done = 1'b0; S_AXI_BREADY = 1'b1;
        @(posedge clk); #1 S_AXI_BREADY = 1'b0;
        m_done = 1; m_result = res;
        axi_read(A_STATUS, d, r, ok, w);
        n_checks++;
        if (!ok || d !== {31'b0, m_done} || core_start !== 1'b0) begin n_fail++; $display("FAIL race_set_wins: status %h start %b expected %h 0", d, core_start, {31'b0, m_done}); end
        axi_write(A_CTRL, 32'h1, 4'hF, 0, ok, w, r);
        m_wgt = 0; m_bias = 0; m_fmap = 0;
        axi_write(A_FMAP, $urandom, 4'hF, 0, ok, w, r);
        m_fmap++;
        axi_write(A_SRST, 32'h1, 4'hF, 0, ok, w, r);
        m_done = 0; m_wgt = 0; m_bias = 0; m_fmap = 0;
        axi_write(A_WGT, $urandom, 4'hF, 0, ok, w, r);
        axi_read(A_COUNT, d, r, ok, w);
        n_checks++;
        if (d !== exp_count() || core_srst !== 1'b1 || core_start !== 1'b1) begin n_fail++; $display("FAIL srst_clear_count: count %h srst %b start %b expected %h 1 1", d, core_srst, core_start, exp_count()); end
        axi_read(A_STATUS, d, r, ok, w);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL srst_clear_done: got %h expected 0", d); end
        axi_write(A_SRST, 32'h0, 4'hF, 0, ok, w, r);
        n_checks++;
        if (core_srst !== 1'b0) begin n_fail++; $display("FAIL srst_release: got %b expected 0", core_srst); end
        $display("test_done_race done: result %0d", res);
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic [1:0] r; bit ok; int w, nf;
        logic [9:0] flags;
        nf = obs_fmap.size();
        fmap_ready = 1'b0;
        @(posedge clk); #1;
        S_AXI_AWADDR = A_FMAP; S_AXI_WDATA = $urandom; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (fmap_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pending: fmap_valid %b expected 1", fmap_valid); end
        #2 S_AXI_ARESETN = 1'b0;
        #1;
        n_checks++;
        if (fmap_valid !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin n_fail++; $display("FAIL arst_async: fmap_valid %b awready %b expected 0 1", fmap_valid, S_AXI_AWREADY); end
        fmap_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 S_AXI_ARESETN = 1'b1;
        m_wgt = 0; m_bias = 0; m_fmap = 0; m_done = 0; m_result = '0;
        @(negedge clk);
        flags = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                 wgt_valid, bias_valid, fmap_valid, core_start, core_srst};
        n_checks++;
        if (flags !== 10'b1110000000 || S_AXI_RDATA !== 32'h0 || fmap_data !== 32'h0) begin n_fail++; $display("FAIL arst_outputs: flags %b rdata %h data %h expected 1110000000 0 0", flags, S_AXI_RDATA, fmap_data); end
        axi_read(A_COUNT, d, r, ok, w);
        n_checks++;
        if (!ok || d !== exp_count()) begin n_fail++; $display("FAIL arst_count: got %h expected %h", d, exp_count()); end
        axi_read(A_RESULT, d, r, ok, w);
        n_checks++;
        if (d !== {28'b0, m_result}) begin n_fail++; $display("FAIL arst_result: got %h expected %h", d, {28'b0, m_result}); end
        n_checks++;
        if (obs_fmap.size() != nf) begin n_fail++; $display("FAIL arst_push_lost: %0d words emitted, expected %0d", obs_fmap.size(), nf); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_streams();
        test_saturation();
        test_backpressure();
        test_done();
        test_split_channels();
        test_done_race();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
